// File: rtl/program_loader.sv
// rtl/program_loader.sv - program RAM writer: two debounced keys, byte-pair entry, sequential word writes
module program_loader #(
  parameter int ADDR_W     = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        SW,
  input  logic              key_byte,
  input  logic              key_done,
  input  logic              load_en,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic              cpu_hold,
  output logic              byte_phase,
  output logic [7:0]        echo,
  output logic [ADDR_W:0]   load_count,
  output logic              done
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WRITE, S_DONE} state_t;

  // Key index 0 is key_byte, index 1 is key_done.
  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d, press_q, press_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  state_t            state_q, state_d;
  logic              prog_we_q, prog_we_d, cpu_hold_q, cpu_hold_d;
  logic              byte_phase_q, byte_phase_d, done_q, done_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic [15:0]       prog_data_q, prog_data_d;
  logic [7:0]        echo_q, echo_d, hi_q, hi_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;

  always_comb begin
    sync1_d = {key_done, key_byte};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    press_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i]   = sync2_q[i];
          press_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    prog_we_d    = 1'b0;
    prog_addr_d  = prog_addr_q;
    prog_data_d  = prog_data_q;
    cpu_hold_d   = cpu_hold_q;
    byte_phase_d = byte_phase_q;
    echo_d       = echo_q;
    hi_d         = hi_q;
    load_count_d = load_count_q;
    done_d       = done_q;
    case (state_q)
      S_IDLE: begin
        cpu_hold_d = 1'b0;
        done_d     = 1'b0;
        if (load_en) begin
          state_d      = S_HI;
          prog_addr_d  = '0;
          load_count_d = '0;
          byte_phase_d = 1'b0;
          cpu_hold_d   = 1'b1;
        end
      end
      S_HI, S_LO: begin
        // load_en beats done, done beats byte.
        if (!load_en) begin
          state_d      = S_IDLE;
          cpu_hold_d   = 1'b0;
          byte_phase_d = 1'b0;
        end else if (press_q[1]) begin
          state_d      = S_DONE;
          cpu_hold_d   = 1'b0;
          done_d       = 1'b1;
          byte_phase_d = 1'b0;
        end else if (press_q[0]) begin
          echo_d = SW;
          if (state_q == S_HI) begin
            hi_d         = SW;
            byte_phase_d = 1'b1;
            state_d      = S_LO;
          end else begin
            prog_data_d = {hi_q, SW};
            prog_we_d   = 1'b1;
            state_d     = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        load_count_d = load_count_q + 1'b1;
        byte_phase_d = 1'b0;
        if (prog_addr_q == ADDR_LAST) begin
          state_d    = S_DONE;
          cpu_hold_d = 1'b0;
          done_d     = 1'b1;
        end else begin
          prog_addr_d = prog_addr_q + 1'b1;
          state_d     = S_HI;
        end
      end
      S_DONE: begin
        if (!load_en) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 2'b11;
      sync2_q      <= 2'b11;
      deb_q        <= 2'b11;
      press_q      <= 2'b00;
      cnt_q[0]     <= '0;
      cnt_q[1]     <= '0;
      state_q      <= S_IDLE;
      prog_we_q    <= 1'b0;
      prog_addr_q  <= '0;
      prog_data_q  <= '0;
      cpu_hold_q   <= 1'b0;
      byte_phase_q <= 1'b0;
      echo_q       <= '0;
      hi_q         <= '0;
      load_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      press_q      <= press_d;
      cnt_q[0]     <= cnt_d[0];
      cnt_q[1]     <= cnt_d[1];
      state_q      <= state_d;
      prog_we_q    <= prog_we_d;
      prog_addr_q  <= prog_addr_d;
      prog_data_q  <= prog_data_d;
      cpu_hold_q   <= cpu_hold_d;
      byte_phase_q <= byte_phase_d;
      echo_q       <= echo_d;
      hi_q         <= hi_d;
      load_count_q <= load_count_d;
      done_q       <= done_d;
    end
  end

  assign prog_we    = prog_we_q;
  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign byte_phase = byte_phase_q;
  assign echo       = echo_q;
  assign load_count = load_count_q;
  assign done       = done_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed and randomized load sessions checked against an event-level model
module tb_program_loader;
  localparam int AW  = 2;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    sw = 8'h00;
  logic          key_byte = 1'b1, key_done = 1'b1, load_en = 1'b0;
  logic          prog_we, cpu_hold, byte_phase, done;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [7:0]    echo;
  logic [AW:0]   load_count;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(AW), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .SW(sw), .key_byte(key_byte), .key_done(key_done),
    .load_en(load_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .cpu_hold(cpu_hold), .byte_phase(byte_phase), .echo(echo),
    .load_count(load_count), .done(done)
  );

  int total = 0, bad = 0;

  typedef enum {M_IDLE, M_HI, M_LO, M_DONE} mstate_e;
  mstate_e ms = M_IDLE;
  int m_addr = 0, m_count = 0, m_phase = 0, m_echo = 0, m_hi = 0;
  int exp_w[$];
  int got_w[$];
  int we_long = 0;
  logic prev_we = 1'b0;

  always @(negedge clk) begin
    if (prog_we) got_w.push_back(int'(prog_addr) * 65536 + int'(prog_data));
    if (prog_we && prev_we) we_long++;
    prev_we = prog_we;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".addr"},  int'(prog_addr),  m_addr);
    check({tag, ".count"}, int'(load_count), m_count);
    check({tag, ".phase"}, int'(byte_phase), m_phase);
    check({tag, ".hold"},  int'(cpu_hold),   (ms == M_HI || ms == M_LO) ? 1 : 0);
    check({tag, ".done"},  int'(done),       (ms == M_DONE) ? 1 : 0);
    check({tag, ".echo"},  int'(echo),       m_echo);
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, ".nwrites"}, got_w.size(), exp_w.size());
    n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) check({tag, ".write"}, got_w[i], exp_w[i]);
    got_w.delete();
    exp_w.delete();
  endtask

  task automatic model_byte(input int b);
    if (ms == M_HI) begin
      m_hi = b; m_echo = b; m_phase = 1; ms = M_LO;
    end else if (ms == M_LO) begin
      m_echo = b;
      exp_w.push_back(m_addr * 65536 + m_hi * 256 + b);
      m_count++;
      m_phase = 0;
      if (m_addr == (1 << AW) - 1) ms = M_DONE;
      else begin m_addr++; ms = M_HI; end
    end
  endtask

  task automatic model_done();
    if (ms == M_HI || ms == M_LO) begin ms = M_DONE; m_phase = 0; end
  endtask

  task automatic set_load(input logic v);
    load_en = v;
    cyc(4);
    if (v && ms == M_IDLE) begin ms = M_HI; m_addr = 0; m_count = 0; m_phase = 0; end
    if (!v) begin ms = M_IDLE; m_phase = 0; end
  endtask

  task automatic press(input logic b, input logic d, input int swv);
    sw = 8'(swv);
    key_byte = ~b;
    key_done = ~d;
    cyc(12);
    key_byte = 1'b1;
    key_done = 1'b1;
    cyc(12);
    if (d) model_done();
    else if (b) model_byte(swv);
  endtask

  task automatic press_word(input int w);
    press(1'b1, 1'b0, (w >> 8) & 255);
    press(1'b1, 1'b0, w & 255);
  endtask

  initial begin
    int n, b;
    cyc(3);
    check_state("reset");
    check("reset.we", int'(prog_we), 0);
    check("reset.data", int'(prog_data), 0);
    rst = 1'b1;
    cyc(2);

    set_load(1'b1);
    check_state("enter");
    press(1'b1, 1'b0, 8'h91);
    check_state("hi91");
    press(1'b1, 1'b0, 8'h05);
    check_state("lo05");
    check_writes("w9105");

    // Bouncy press and release of key_byte
    sw = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      key_byte = 1'b0; cyc(2); key_byte = 1'b1; cyc(2);
    end
    key_byte = 1'b0; cyc(12);
    for (int i = 0; i < 3; i++) begin
      key_byte = 1'b1; cyc(2); key_byte = 1'b0; cyc(2);
    end
    key_byte = 1'b1; cyc(12);
    model_byte(8'h3C);
    check_state("bounce");
    check_writes("bounce");
    set_load(1'b0);
    check_state("drop_lo");
    check_writes("drop_lo");

    set_load(1'b1);
    press_word(16'h9005);
    press_word(16'h9103);
    press_word(16'h1000);
    press(1'b0, 1'b1, 0);
    check_state("three_done");
    check_writes("three");
    set_load(1'b0);
    check_state("three_idle");

    set_load(1'b1);
    press(1'b1, 1'b0, 8'hAB);
    press(1'b0, 1'b1, 0);
    check_state("abort_lo");
    check_writes("abort_lo");
    set_load(1'b0);

    set_load(1'b1);
    press(1'b1, 1'b1, 8'h77);
    check_state("both");
    check_writes("both");
    set_load(1'b0);

    set_load(1'b1);
    for (int i = 0; i < 4; i++) press_word(int'($urandom_range(0, 65535)));
    check_state("full");
    press_word(16'h1234);
    check_state("full_extra");
    check_writes("full");
    set_load(1'b0);

    for (int s = 0; s < 4; s++) begin
      set_load(1'b1);
      n = int'($urandom_range(0, 9));
      for (int i = 0; i < n; i++) begin
        b = int'($urandom_range(0, 255));
        press(1'b1, 1'b0, b);
      end
      if ($urandom_range(0, 1) == 1) press(1'b0, 1'b1, 0);
      check_state("rand");
      check_writes("rand");
      set_load(1'b0);
      check_state("rand_idle");
    end

    set_load(1'b1);
    press(1'b1, 1'b0, 8'h5A);
    check_state("pre_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    ms = M_IDLE; m_addr = 0; m_count = 0; m_phase = 0; m_echo = 0;
    check_state("async_rst");
    check("async_rst.we", int'(prog_we), 0);
    check("async_rst.data", int'(prog_data), 0);
    cyc(2);
    rst = 1'b1;
    cyc(4);
    ms = M_HI;
    check_state("restart");
    press_word(16'hC3E1);
    check_state("restart_word");
    check_writes("restart");
    set_load(1'b0);

    check("we_one_cycle", we_long, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
